// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline definitions: bubble control constants and per-stage control field layouts,
// so every stage packs and unpacks its ctrl field the same way.
package pipe_stage_buffer_pkg;

    typedef enum logic [2:0] {
        ATOMIC_NO_OP = 3'd0,
        ATOMIC_LR    = 3'd1,
        ATOMIC_SC    = 3'd2,
        ATOMIC_SWAP  = 3'd3,
        ATOMIC_ADD   = 3'd4,
        ATOMIC_AND   = 3'd5,
        ATOMIC_OR    = 3'd6,
        ATOMIC_XOR   = 3'd7
    } atomic_op_e;

    typedef enum logic [1:0] {
        OP_LEN_BYTE   = 2'd0,
        OP_LEN_HALF   = 2'd1,
        OP_LEN_WORD   = 2'd2,
        OP_LEN_DOUBLE = 2'd3
    } op_length_e;

    // EX/MEM control layout, LSB first: reg_write, mem_write, mem_read, op_length, atomic_op.
    localparam int MEM_CTRL_REG_WRITE_BIT = 0;
    localparam int MEM_CTRL_MEM_WRITE_BIT = 1;
    localparam int MEM_CTRL_MEM_READ_BIT  = 2;
    localparam int MEM_CTRL_OP_LEN_LSB    = 3;
    localparam int MEM_CTRL_OP_LEN_WIDTH  = 2;
    localparam int MEM_CTRL_ATOMIC_LSB    = 5;
    localparam int MEM_CTRL_ATOMIC_WIDTH  = 3;
    localparam int MEM_CTRL_WIDTH         = 8;

    // MEM/WB control layout: reg_write only, plus a load-result select.
    localparam int WB_CTRL_REG_WRITE_BIT = 0;
    localparam int WB_CTRL_FROM_MEM_BIT  = 1;
    localparam int WB_CTRL_WIDTH         = 2;

    typedef struct packed {
        atomic_op_e atomic_op;
        op_length_e op_length;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
    } mem_ctrl_t;

    localparam mem_ctrl_t MEM_CTRL_BUBBLE = '{
        atomic_op: ATOMIC_NO_OP,
        op_length: OP_LEN_BYTE,
        mem_read:  1'b0,
        mem_write: 1'b0,
        reg_write: 1'b0
    };

    localparam logic [WB_CTRL_WIDTH-1:0] WB_CTRL_BUBBLE = '0;

    function automatic logic [MEM_CTRL_WIDTH-1:0] pack_mem_ctrl(input mem_ctrl_t c);
        return c;
    endfunction

    function automatic mem_ctrl_t unpack_mem_ctrl(input logic [MEM_CTRL_WIDTH-1:0] raw);
        return mem_ctrl_t'(raw);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_buffer.sv
// Generic pipeline stage register: main + skid slot with a registered in_ready and sync flush.
// Define PIPE_STAGE_STALL_CNT_EN to build the saturating downstream-stall counter.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    CTRL_WIDTH  = 8,
    parameter logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [31:0]           stall_count
);

    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic                  in_ready_q;

    logic accept;
    logic transfer;
    logic main_free;
    logic main_from_skid;
    logic main_from_in;
    logic skid_from_in;
    logic main_valid_nxt;
    logic skid_valid_nxt;

    // The skid only fills while main is stuck, so in_ready (= !skid_valid) never gates a skid move.
    always_comb begin
        accept         = in_valid && in_ready_q;
        transfer       = main_valid && out_ready;
        main_free      = !main_valid || transfer;
        main_from_skid = main_free && skid_valid;
        main_from_in   = main_free && !skid_valid && accept;
        skid_from_in   = !main_free && accept;
        main_valid_nxt = 1'b0;
        skid_valid_nxt = 1'b0;
        if (!flush) begin
            main_valid_nxt = main_free ? (skid_valid || accept) : 1'b1;
            skid_valid_nxt = main_from_skid ? 1'b0 : (skid_valid || skid_from_in);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready_q <= !skid_valid_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_data <= '0;
            main_ctrl <= BUBBLE_CTRL;
        end else if (flush) begin
            main_ctrl <= BUBBLE_CTRL;
        end else if (main_from_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
        end else if (main_from_in) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
        end else if (transfer) begin
            main_ctrl <= BUBBLE_CTRL;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            skid_data <= '0;
            skid_ctrl <= BUBBLE_CTRL;
        end else if (skid_from_in && !flush) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_q;

    // Only reset clears the counter; a flush leaves the history intact.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready) begin
            stall_q <= sat_inc32(stall_q);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule
